regfile_wport_arbiter: RTL and testbench
========================================

# regfile_wport_arbiter

Controller for the CPU register file's single write port (WE3/AD3/WD3) and issue-hazard scoreboard. Two writers share the port: the in-order pipeline writeback and the long-latency multiply/divide unit. Pipeline writeback has default priority; a starvation counter forces the muldiv result through after a bounded wait. A per-register pending scoreboard stalls decode on RAW/WAW hazards against in-flight muldiv results.

## Interface
- STARVE_MAX, 4: cycles a held muldiv result may lose arbitration before it is forced; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  pipeline writeback wants the port this cycle.
- wb_rd  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- wb_stall  out  1  pipeline must hold wb_* stable; writeback not performed this cycle.
- md_issue_valid  in  1  muldiv operation launched this cycle.
- md_issue_rd  in  5  destination of the launched operation.
- md_valid  in  1  muldiv result available.
- md_rd  in  5  result destination.
- md_data  in  32  result data.
- md_ready  out  1  result accepted on the edge where md_valid && md_ready.
- dec_rs1, dec_rs2, dec_rd  in  5 each  registers of the instruction in decode.
- issue_stall  out  1  decode must not advance.
- we3  out  1  regfile write enable.
- ad3  out  5  regfile write address.
- wd3  out  32  regfile write data.

## Operation
- State: FSM {IDLE, WAIT, FORCE}; hold register {hold_rd[4:0], hold_data[31:0]}; wait_cnt[3:0]; pending[31:1] (x0 has no bit, never pending).
- md_ready = (state == IDLE). On accept: hold <= md_rd/md_data, state -> WAIT, wait_cnt <= 0.
- Port mux (combinational):
  - FORCE: source = hold, wb_stall = 1.
  - else wb_valid: source = wb, wb_stall = 0.
  - else WAIT: source = hold ("hold granted").
  - else no write.
- we3 = source selected && its rd != 0; ad3/wd3 = selected rd/data; when we3 = 0, ad3 = 0, wd3 = 0. A source with rd = 0 is consumed (hold drains) but nothing is written.
- WAIT: hold granted -> IDLE. Not granted: wait_cnt++; if wait_cnt == STARVE_MAX-1 -> FORCE. FORCE -> IDLE unconditionally.
- Scoreboard: on edge, md_issue_valid && md_issue_rd != 0 sets pending[md_issue_rd]. Hold draining with hold_rd != 0 clears pending[hold_rd]. Set and clear on the same register in the same cycle: set wins.
- issue_stall = OR over {dec_rs1, dec_rs2, dec_rd}, each nonzero and pending. Combinational, from current pending.
- md result whose rd is not pending is still written; not an error.
- Pipeline writeback is never blocked except in FORCE.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, hold cleared, wait_cnt 0, pending all 0. While low: we3 = 0, ad3 = 0, wd3 = 0, wb_stall = 0, issue_stall = 0, md_ready = 0. After release: md_ready = 1.
- Reset mid-operation discards the held result and all pending bits; no partial write.
- Muldiv latency: accepted at edge N. Written at edge N+1 if wb idle in cycle N+1; worst case at edge N+1+STARVE_MAX (FORCE cycle).
- pending clears on the same edge the regfile commits the write. issue_stall drops in the following cycle, and the regfile's combinational read returns the new value.
- Throughput: at most one muldiv result per 2 cycles (IDLE required to accept).
- During FORCE the pipeline's wb request is deferred exactly one cycle. No writeback is lost, because wb_* is held stable.

## Test plan
- Issue rd=5, dec_rs1=5 -> issue_stall=1. md_valid rd=5 data=0xDEADBEEF accepted at edge N, wb idle -> cycle N+1: we3=1, ad3=5, wd3=0xDEADBEEF. issue_stall=0 from cycle N+2.
- wb_valid=1 continuously (rd=3, 0x11), md result rd=7 data=0x77 accepted at N -> wb written cycles N+1..N+4. FORCE in cycle N+5: wb_stall=1, ad3=7, wd3=0x77. Cycle N+6: ad3=3, wb_stall=0.
- md_issue_valid rd=9 in the same cycle the hold drains rd=9 -> pending[9] remains 1 and dec_rd=9 still stalls.
- md_issue rd=0 -> no pending change. md result rd=0 -> we3=0, FSM returns to IDLE. wb_valid with wb_rd=0 -> we3=0.
- md_valid held high while state WAIT -> md_ready=0. Data accepted on the edge after hold drains, then written once with the correct value.
- Assert rst_n low during WAIT with pending[12]=1 -> outputs immediately at reset values, no write of held data. After release: pending[12]=0, md_ready=1.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: arbitrates the register file's single write port
// between pipeline writeback and the muldiv unit. It also keeps a pending
// scoreboard of in-flight muldiv destinations so that decode stalls on
// RAW/WAW hazards.
module regfile_wport_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        md_issue_valid,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        issue_stall,
  output logic        we3,
  output logic [4:0]  ad3,
  output logic [31:0] wd3
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t      state, state_next;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic [31:1] pending, pending_next;
  logic [31:0] pending_vec;

  logic        accept;
  logic        wb_sel;
  logic        hold_sel;
  logic [4:0]  src_rd;
  logic [31:0] src_data;

  // The hold register only takes a new result from IDLE. Outputs are gated
  // while reset is low, so md_ready stays 0 during reset.
  assign md_ready = rst_n && (state == IDLE);
  assign accept   = md_valid && md_ready;

  // Write-port mux: FORCE beats writeback, writeback beats a waiting hold.
  always_comb begin
    wb_sel   = 1'b0;
    hold_sel = 1'b0;
    wb_stall = 1'b0;
    src_rd   = 5'd0;
    src_data = 32'd0;
    if (state == FORCE) begin
      hold_sel = 1'b1;
      wb_stall = 1'b1;
      src_rd   = hold_rd;
      src_data = hold_data;
    end else if (wb_valid) begin
      wb_sel   = 1'b1;
      src_rd   = wb_rd;
      src_data = wb_data;
    end else if (state == WAIT) begin
      hold_sel = 1'b1;
      src_rd   = hold_rd;
      src_data = hold_data;
    end
  end

  // A source targeting x0 is consumed, but nothing is written to the port.
  assign we3 = rst_n && (wb_sel || hold_sel) && (src_rd != 5'd0);
  assign ad3 = we3 ? src_rd : 5'd0;
  assign wd3 = we3 ? src_data : 32'd0;

  // Next-state logic: a held result drains when granted. After losing
  // STARVE_MAX rounds, it is forced through for one cycle.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next    = WAIT;
          wait_cnt_next = 4'd0;
        end
      end
      WAIT: begin
        if (hold_sel) begin
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
          if (wait_cnt == 4'(STARVE_MAX - 1)) begin
            state_next = FORCE;
          end
        end
      end
      FORCE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, starvation counter and hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      hold_rd   <= 5'd0;
      hold_data <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        hold_rd   <= md_rd;
        hold_data <= md_data;
      end
    end
  end

  // Scoreboard update: an issue sets the bit and a draining hold clears it.
  // If both hit the same register, the set wins.
  always_comb begin
    pending_next = pending;
    for (int i = 1; i < 32; i++) begin
      pending_next[i] = (md_issue_valid && (md_issue_rd == 5'(i))) ||
                        (pending[i] && !(hold_sel && (hold_rd == 5'(i))));
    end
  end

  // Pending scoreboard register. x0 never has a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // Bit 0 is tied low, so x0 operands never stall decode.
  assign pending_vec = {pending, 1'b0};
  assign issue_stall = pending_vec[dec_rs1] | pending_vec[dec_rs2] | pending_vec[dec_rd];

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed vectors with hand-computed expectations
// for the register-file write-port arbiter (STARVE_MAX = 4).
module tb_regfile_wport_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_issue_valid;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        issue_stall;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;

  int checks;
  int errors;

  regfile_wport_arbiter #(.STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_stall       (wb_stall),
    .md_issue_valid (md_issue_valid),
    .md_issue_rd    (md_issue_rd),
    .md_valid       (md_valid),
    .md_rd          (md_rd),
    .md_data        (md_data),
    .md_ready       (md_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .issue_stall    (issue_stall),
    .we3            (we3),
    .ad3            (ad3),
    .wd3            (wd3)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive both writers for the current cycle, then let the combinational logic settle.
  task automatic applyStimulus(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                               input logic mv, input logic [4:0] mr, input logic [31:0] mdat);
    wb_valid = wv;
    wb_rd    = wr;
    wb_data  = wd;
    md_valid = mv;
    md_rd    = mr;
    md_data  = mdat;
    #1;
  endtask

  // Advance to just past the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPort(input string tag, input logic we, input logic [4:0] ad, input logic [31:0] wd);
    checkOutput({tag, ".we3"}, 32'(we3), 32'(we));
    checkOutput({tag, ".ad3"}, 32'(ad3), 32'(ad));
    checkOutput({tag, ".wd3"}, wd3, wd);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    md_issue_valid = 1'b0;
    md_issue_rd = 5'd0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    dec_rd = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    #2;

    // Reset state: all outputs at their reset values, even with writeback requesting.
    checkPort("reset", 1'b0, 5'd0, 32'h0);
    checkOutput("reset.wb_stall", 32'(wb_stall), 32'd0);
    checkOutput("reset.issue_stall", 32'(issue_stall), 32'd0);
    checkOutput("reset.md_ready", 32'(md_ready), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset.md_ready", 32'(md_ready), 32'd1);

    // Test 1: RAW stall on rd=5, with a fast write because writeback is idle.
    md_issue_valid = 1'b1;
    md_issue_rd = 5'd5;
    nextCycle();
    md_issue_valid = 1'b0;
    dec_rs1 = 5'd5;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("t1.stall_set", 32'(issue_stall), 32'd1);
    checkOutput("t1.md_ready", 32'(md_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkPort("t1.write", 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("t1.stall_hold", 32'(issue_stall), 32'd1);
    checkOutput("t1.md_busy", 32'(md_ready), 32'd0);
    nextCycle();
    checkOutput("t1.stall_clear", 32'(issue_stall), 32'd0);
    checkPort("t1.idle", 1'b0, 5'd0, 32'h0);
    dec_rs1 = 5'd0;

    // Test 2: continuous writeback starves the hold until FORCE.
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h77);
    checkPort("t2.wb0", 1'b1, 5'd3, 32'h11);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      checkPort($sformatf("t2.wb%0d", i), 1'b1, 5'd3, 32'h11);
      checkOutput($sformatf("t2.wb_stall%0d", i), 32'(wb_stall), 32'd0);
      nextCycle();
    end
    checkPort("t2.force", 1'b1, 5'd7, 32'h77);
    checkOutput("t2.force_stall", 32'(wb_stall), 32'd1);
    nextCycle();
    checkPort("t2.after", 1'b1, 5'd3, 32'h11);
    checkOutput("t2.after_stall", 32'(wb_stall), 32'd0);
    checkOutput("t2.md_ready", 32'(md_ready), 32'd1);

    // Test 3: a re-issue to rd=9 in the drain cycle keeps pending[9] set.
    md_issue_valid = 1'b1;
    md_issue_rd = 5'd9;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkPort("t3.drain", 1'b1, 5'd9, 32'h99);
    nextCycle();
    md_issue_valid = 1'b0;
    md_issue_rd = 5'd0;
    dec_rd = 5'd9;
    #1;
    checkOutput("t3.set_wins", 32'(issue_stall), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkPort("t3.second", 1'b1, 5'd9, 32'h9A);
    nextCycle();
    checkOutput("t3.cleared", 32'(issue_stall), 32'd0);
    dec_rd = 5'd0;

    // Test 4: x0 destinations are consumed without any write.
    md_issue_valid = 1'b1;
    md_issue_rd = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    nextCycle();
    md_issue_valid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkPort("t4.md_x0", 1'b0, 5'd0, 32'h0);
    checkOutput("t4.x0_stall", 32'(issue_stall), 32'd0);
    nextCycle();
    checkOutput("t4.idle_again", 32'(md_ready), 32'd1);
    applyStimulus(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'h0);
    checkPort("t4.wb_x0", 1'b0, 5'd0, 32'h0);

    // Test 5: md_valid held high while the hold waits for the port.
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hA0);
    nextCycle();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hB0);
    checkOutput("t5.not_ready", 32'(md_ready), 32'd0);
    checkPort("t5.wb", 1'b1, 5'd4, 32'h44);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB0);
    checkPort("t5.drain", 1'b1, 5'd10, 32'hA0);
    checkOutput("t5.drain_ready", 32'(md_ready), 32'd0);
    nextCycle();
    checkOutput("t5.ready", 32'(md_ready), 32'd1);
    checkPort("t5.idle", 1'b0, 5'd0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkPort("t5.second", 1'b1, 5'd11, 32'hB0);
    nextCycle();
    checkPort("t5.once", 1'b0, 5'd0, 32'h0);

    // Test 6: reset during WAIT discards the held result and pending bits.
    md_issue_valid = 1'b1;
    md_issue_rd = 5'd12;
    nextCycle();
    md_issue_valid = 1'b0;
    md_issue_rd = 5'd0;
    dec_rs2 = 5'd12;
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd12, 32'hC0);
    nextCycle();
    applyStimulus(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
    checkOutput("t6.wait_busy", 32'(md_ready), 32'd0);
    checkOutput("t6.pending", 32'(issue_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    checkPort("t6.in_reset", 1'b0, 5'd0, 32'h0);
    checkOutput("t6.rst_wb_stall", 32'(wb_stall), 32'd0);
    checkOutput("t6.rst_issue_stall", 32'(issue_stall), 32'd0);
    checkOutput("t6.rst_md_ready", 32'(md_ready), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("t6.pending_gone", 32'(issue_stall), 32'd0);
    checkOutput("t6.ready", 32'(md_ready), 32'd1);
    checkPort("t6.no_write", 1'b0, 5'd0, 32'h0);
    nextCycle();
    checkPort("t6.no_write2", 1'b0, 5'd0, 32'h0);
    dec_rs2 = 5'd0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
